// File: rtl/tree_arbiter.sv
// Round-robin arbiter sharing one external pipelined reduction tree among NUM_REQ requesters.
// Optional per-requester grant counters are enabled with `define TREE_ARB_STATS_EN.
module tree_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int TREE_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tree_a,
  input  logic                      tree_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_data,
  input  logic                      pause,
  output logic                      idle
`ifdef TREE_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

  state_t          state_q;
  logic            idle_q;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TREE_LAT-1:0] tag_vld_q;
  logic [ID_W-1:0] tag_id_q [TREE_LAT];
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic            pipe_empty;
  logic            tail_vld;

  // Scan from rr_ptr upward, wrapping at NUM_REQ; grants are suppressed outside RUN and during reset.
  always_comb begin
    logic [ID_W:0] sum;
    sum       = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!grant_any && req_valid[sum[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = sum[ID_W-1:0];
      end
    end
    if (rst || state_q != RUN) grant_any = 1'b0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
  end

  assign req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  assign tree_a    = grant_any ? req_data[grant_id*DATA_W +: DATA_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q[0] <= 1'b0;
      tag_id_q[0]  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      tag_vld_q[0] <= grant_any;
      tag_id_q[0]  <= grant_id;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  generate
    for (genvar gi = 1; gi < TREE_LAT; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_vld_q[gi] <= 1'b0;
          tag_id_q[gi]  <= '0;
        end else begin
          tag_vld_q[gi] <= tag_vld_q[gi-1];
          tag_id_q[gi]  <= tag_id_q[gi-1];
        end
      end
    end
  endgenerate

  assign pipe_empty = ~|tag_vld_q;
  assign tail_vld   = tag_vld_q[TREE_LAT-1] & ~rst;
  assign resp_valid = tail_vld ? (NUM_REQ'(1) << tag_id_q[TREE_LAT-1]) : '0;
  assign resp_data  = tail_vld & tree_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      idle_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) state_q <= DRAIN;
          idle_q <= 1'b0;
        end
        DRAIN: begin
          if (!pause) begin
            state_q <= RUN;
            idle_q  <= 1'b0;
          end else if (pipe_empty) begin
            state_q <= PAUSED;
            idle_q  <= 1'b1;
          end else begin
            idle_q  <= 1'b0;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_q <= RUN;
            idle_q  <= 1'b0;
          end else begin
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  assign idle = idle_q;

`ifdef TREE_ARB_STATS_EN
  // Clear has priority over an increment landing in the same cycle.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [15:0] cnt_q;
      always_ff @(posedge clk) begin
        if (rst || stats_clr) cnt_q <= '0;
        else if (grant_any && grant_id == ID_W'(gi) && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
      assign grant_cnt[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_tree_arbiter.sv
// Scoreboard bench for tree_arbiter with a behavioural tree (popcount==2 detector, 3-cycle latency).
module tb_tree_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [63:0]  req_data = '0;
  logic [N-1:0] req_ready;
  logic [15:0]  tree_a;
  logic         tree_b;
  logic [N-1:0] resp_valid;
  logic         resp_data;
  logic         pause = 1'b0;
  logic         idle;
`ifdef TREE_ARB_STATS_EN
  logic         stats_clr = 1'b0;
  logic [63:0]  grant_cnt;
  int           cnt_m [N];
`endif

  tree_arbiter #(.NUM_REQ(N), .DATA_W(16), .TREE_LAT(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tree_a(tree_a), .tree_b(tree_b),
    .resp_valid(resp_valid), .resp_data(resp_data), .pause(pause), .idle(idle)
`ifdef TREE_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic tree_fn(input logic [15:0] x);
    return ($countones(x) == 2);
  endfunction

  // External tree: result appears three cycles after its operand.
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  always @(posedge clk) begin
    s1 <= tree_fn(tree_a);
    s2 <= s1;
    s3 <= s2;
  end
  assign tree_b = s3;

  typedef struct { int id; logic b; int due; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int rr_m = 0;
  int last_acc = -100;
  typedef enum {M_RUN, M_DRAIN, M_PAUSED} mode_t;
  mode_t mode = M_RUN;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic logic [63:0] rand_data();
    logic [63:0] d;
    for (int i = 0; i < N; i++)
      d[i*16 +: 16] = $urandom_range(0, 1) ? (16'(1) << $urandom_range(0, 7)) | (16'(1) << $urandom_range(8, 15))
                                           : 16'($urandom);
    return d;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [63:0] d, input logic p, input logic r);
    int g;
    logic [N-1:0] exp_ready;
    logic [15:0]  exp_a;
    req_valid = v; req_data = d; pause = p; rst = r;
    #1;
    g = (r || mode != M_RUN) ? -1 : pick(v, rr_m);
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    exp_a     = (g >= 0) ? d[g*16 +: 16] : 16'h0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("tree_a", 64'(tree_a), 64'(exp_a));
    if (!r) chk("idle", 64'(idle), 64'(mode == M_PAUSED));
`ifdef TREE_ARB_STATS_EN
    if (!r) for (int i = 0; i < N; i++) chk($sformatf("grant_cnt%0d", i), 64'(grant_cnt[i*16 +: 16]), 64'(cnt_m[i]));
`endif
    if (r) sb.delete();
    else if (g >= 0) begin
      sb.push_back('{id: g, b: tree_fn(exp_a), due: cyc + 3});
      $display("cyc=%0d grant req%0d data=%04h", cyc, g, exp_a);
    end
    @(posedge clk);
`ifdef TREE_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      if (r || stats_clr) cnt_m[i] = 0;
      else if (g == i && cnt_m[i] < 65535) cnt_m[i]++;
    end
`endif
    if (r) begin
      mode = M_RUN; rr_m = 0; last_acc = -100;
    end else begin
      case (mode)
        M_RUN:    if (p) mode = M_DRAIN;
        M_DRAIN:  if (!p) mode = M_RUN; else if (cyc - last_acc > 3) mode = M_PAUSED;
        M_PAUSED: if (!p) mode = M_RUN;
        default:  mode = M_RUN;
      endcase
      if (g >= 0) begin
        rr_m = (g + 1) % N;
        last_acc = cyc;
      end
    end
    cyc++;
    #1;
  endtask

  // Monitor: every presented response must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (resp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_valid", 64'(resp_valid), 64'(N'(1) << e.id));
        chk("resp_data", 64'(resp_data), 64'(e.b));
        chk("resp_cycle", 64'(cyc), 64'(e.due));
        $display("cyc=%0d resp req%0d bit=%0b", cyc, e.id, resp_data);
      end
    end else begin
      if (resp_data !== 1'b0) chk("resp_data_idle", 64'(resp_data), 64'(0));
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missing_resp", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step('0, '0, 1'b0, 1'b0);
    // single op from requester 0
    step(4'b0001, 64'h0000_0000_0000_0101, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0, 1'b0);
    // back-to-back from requester 2
    step(4'b0100, 64'h0000_FFFF_0000_0000, 1'b0, 1'b0);
    step(4'b0100, 64'h0000_0404_0000_0000, 1'b0, 1'b0);
    step(4'b0100, 64'h0000_0303_0000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0, 1'b0);
    // all requesting continuously
    for (int i = 0; i < 12; i++) step(4'b1111, rand_data(), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(N'($urandom), rand_data(), 1'b0, 1'b0);
    // pause with traffic, hold until drained, then resume
    step(4'b1111, rand_data(), 1'b0, 1'b0);
    step(4'b1111, rand_data(), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(N'($urandom), rand_data(), 1'b1, 1'b0);
    chk("paused_after_drain", 64'(idle), 64'(1));
    for (int i = 0; i < 4; i++) step(4'b1111, rand_data(), 1'b0, 1'b0);
    // pause released while still draining
    step(4'b1111, rand_data(), 1'b1, 1'b0);
    step(4'b1111, rand_data(), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b1111, rand_data(), 1'b0, 1'b0);
    // reset with ops in flight
    step(4'b1111, rand_data(), 1'b0, 1'b0);
    step(4'b1111, rand_data(), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0, 1'b0);
    step(4'b1111, rand_data(), 1'b0, 1'b0);
    // mixed random traffic, pause and occasional reset
    for (int i = 0; i < 400; i++)
      step(N'($urandom), rand_data(), ($urandom_range(0, 9) < 2), ($urandom_range(0, 99) == 0));
`ifdef TREE_ARB_STATS_EN
    stats_clr = 1'b1;
    step('0, '0, 1'b0, 1'b0);
    stats_clr = 1'b0;
    for (int i = 0; i < 70000; i++) step(4'b0010, rand_data(), 1'b0, 1'b0);
    chk("grant_cnt1_sat", 64'(grant_cnt[31:16]), 64'(cnt_m[1]));
    stats_clr = 1'b1;
    step(4'b0010, rand_data(), 1'b0, 1'b0);
    stats_clr = 1'b0;
    step('0, '0, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0, 1'b0);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
